ether_import: RTL
=================

# ether_import

RMII receive-side counterpart to the frame exporter. It deserialises 2-bit RMII receive dibits into bytes, validates the Ethernet framing (preamble/SFD, EtherType, CRC-32 FCS), and writes the frame's 4-bit pixel payload into the frame-buffer BRAM write port at a pixel offset carried in the frame. It sits between the PHY receive pins and `bram_manager`'s write side, and reports a per-frame status pulse to control logic.

## Interface

**Parameters**
- `ADDR_BITS`, default 17: pixel address width. Addresses wrap modulo 2^ADDR_BITS.
- `ETHERTYPE`, default 16'h88B5: accepted EtherType.

**Ports**
- `clk_in`  in  1  50 MHz RMII reference clock. One dibit is sampled per cycle.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `eth_crsdv`  in  1  RMII carrier sense / data valid.
- `eth_rxd`  in  2  RMII receive dibit. LSB dibit of each byte arrives first.
- `write_addr_out`  out  ADDR_BITS  BRAM pixel write address.
- `write_data_out`  out  4  pixel nibble.
- `write_enable_out`  out  1  one-cycle write strobe.
- `frame_done_out`  out  1  one-cycle pulse at the end of every frame that passed SFD.
- `frame_ok_out`  out  1  frame status. Valid only while `frame_done_out` is high.

## Operation

**Reset.** Asserting reset clears every output and register to 0 and forces state WAIT_IDLE.

**States**
- **WAIT_IDLE**
  - `eth_crsdv` low → HUNT.
  - Prevents locking onto a frame already in progress, for example after reset is released mid-frame.
- **HUNT**
  - `eth_crsdv` low: stay and clear the preamble count.
  - `eth_crsdv` high:
    - rxd 00 before any 01: stay.
    - rxd 01: increment the saturating preamble count.
    - rxd 11 with count ≥ 4: → RX, init CRC to 32'hFFFFFFFF, clear the byte and dibit counters.
    - Any other sequence → DROP.
- **RX**
  - Shift in dibits; every 4th dibit completes a byte.
  - Update CRC-32 (reflected, poly 32'hEDB88320) on every received byte, FCS included.
  - Every completed byte enters a 4-byte delay line. When byte k completes with k ≥ 4, byte k−4 is released to the parser, so the 4 FCS bytes are never parsed as payload.
- **DROP**
  - Wait for `eth_crsdv` low → HUNT.
  - No `frame_done_out`.

**Parser (by index j of the released byte)**
- j 0–11: MAC addresses. Ignored, no filtering.
- j 12, 13: EtherType, big-endian (j 12 is the MSB). On mismatch, set `type_bad`; all further pixel writes for the frame are suppressed.
- j 14, 15, 16: pixel offset, little-endian 24 bits, truncated to ADDR_BITS. Loads the address counter.
- j ≥ 17 with `type_bad` clear: pixel byte.
  - Write the low nibble at the current address, then the high nibble at address+1.
  - The counter then advances by 2, mod 2^ADDR_BITS.

**End of frame.** `eth_crsdv` sampled low in RX ends the frame and returns to HUNT. `frame_ok_out` = 1 iff all of the following hold:
- the dibit count is a multiple of 4;
- byte count ≥ 21;
- `type_bad` is clear;
- the CRC register equals the residue 32'hDEBB20E3.

Writes already issued are not retracted on a bad frame.

## Timing

- All outputs are registered.
- Byte k's last dibit is sampled at cycle t:
  - The released byte k−4 produces its low-nibble write at cycle t+1 and its high-nibble write at t+2.
  - Both writes finish before the next byte completes at t+4.
- Pixel latency is 4 byte-times: a pixel byte is written 17–18 cycles after its own last dibit.
- `write_enable_out` is never high on two consecutive cycles for unrelated bytes. It is low in every cycle not listed above.
- `eth_crsdv` is sampled low at cycle t:
  - `frame_done_out` = 1 at t+2 for exactly one cycle, with `frame_ok_out` valid in that cycle.
  - The trailing 4 bytes are discarded from the delay line.
- A new frame can be accepted 1 cycle after `eth_crsdv` low: the preamble of the next frame is hunted while `frame_done_out` is pending.
- Address wrap: a write at 2^ADDR_BITS−1 is followed by a write at 0.
- Reset asserted mid-frame: outputs go to 0 immediately, including any in-flight write strobe or done pulse.

## Test plan

1. **Good frame.** 7 preamble bytes 0x55, SFD 0xD5, any MACs, type 0x88B5, offset 0x000010, payload 0x21 0x43, valid FCS.
   - Writes (addr, data): (0x10, 1), (0x11, 2), (0x12, 3), (0x13, 4).
   - One `frame_done_out` pulse with `frame_ok_out` = 1, 2 cycles after `eth_crsdv` falls.
2. **Corrupt FCS.** Same frame with one FCS bit flipped → identical four writes, `frame_done_out` = 1, `frame_ok_out` = 0.
3. **Wrong EtherType.** Type 0x0800, valid FCS → zero writes, `frame_done_out` = 1, `frame_ok_out` = 0.
4. **Wrap-around.** Offset 0x01FFFF (ADDR_BITS = 17), payload 0xBA → writes (0x1FFFF, 0xA), then (0x00000, 0xB).
5. **Reset mid-frame.** Pull `rst_n_in` low during payload and release while `eth_crsdv` is still high.
   - No writes and no `frame_done_out` for the remainder of that frame.
   - The next good frame is received exactly as in scenario 1.
6. **Truncated / runt frames.**
   - A frame ending after a non-multiple-of-4 dibit count → `frame_ok_out` = 0.
   - A 20-byte frame → `frame_ok_out` = 0 and no pixel writes.

Source files
------------

// File: rtl/ether_import.sv
// RMII receive path: dibit deserialiser, preamble/SFD hunt, CRC-32 check and
// pixel-payload parser feeding the frame-buffer write port.
module ether_import #(
    parameter int unsigned ADDR_BITS = 17,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 eth_crsdv,
    input  logic [1:0]           eth_rxd,
    output logic [ADDR_BITS-1:0] write_addr_out,
    output logic [3:0]           write_data_out,
    output logic                 write_enable_out,
    output logic                 frame_done_out,
    output logic                 frame_ok_out
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {WAIT_IDLE, HUNT, RX, DROP} state_t;

    state_t state_q, state_d;
    logic [2:0] pre_q, pre_d;
    logic       start_rx, byte_done, eof;

    logic [5:0]           sr_q;
    logic [1:0]           dib_q;
    logic [15:0]          byte_cnt_q;
    logic [3:0][7:0]      dly_q;
    logic [31:0]          crc_q;
    logic                 type_bad_q;
    logic [15:0]          off_q;
    logic [ADDR_BITS-1:0] addr_cnt_q;
    logic                 hi_pend_q;
    logic [3:0]           hi_data_q;
    logic                 eof_q, eof_ok_q;
    logic [ADDR_BITS-1:0] waddr_q;
    logic [3:0]           wdata_q;
    logic                 we_q, done_q, ok_q;

    logic [7:0]  new_byte, rel_byte;
    logic [15:0] rel_idx;
    logic        rel_valid, pix_wr;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    // Bytes are released 4 behind the receive point so the FCS never reaches the parser.
    assign new_byte  = {eth_rxd, sr_q};
    assign rel_byte  = dly_q[3];
    assign rel_valid = byte_done && (byte_cnt_q >= 16'd4);
    assign rel_idx   = byte_cnt_q - 16'd4;
    assign pix_wr    = rel_valid && (rel_idx >= 16'd17) && !type_bad_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= WAIT_IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = '0;
        start_rx  = 1'b0;
        byte_done = 1'b0;
        eof       = 1'b0;
        case (state_q)
            WAIT_IDLE: if (!eth_crsdv) state_d = HUNT;
            HUNT: begin
                if (eth_crsdv) begin
                    case (eth_rxd)
                        2'b00: if (pre_q != 3'd0) state_d = DROP;
                        2'b01: pre_d = (pre_q == 3'd7) ? pre_q : pre_q + 3'd1;
                        2'b11: begin
                            if (pre_q >= 3'd4) begin
                                state_d  = RX;
                                start_rx = 1'b1;
                            end else begin
                                state_d = DROP;
                            end
                        end
                        default: state_d = DROP;
                    endcase
                end
            end
            RX: begin
                if (!eth_crsdv) begin
                    eof     = 1'b1;
                    state_d = HUNT;
                end else begin
                    byte_done = (dib_q == 2'd3);
                end
            end
            DROP: if (!eth_crsdv) state_d = HUNT;
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sr_q       <= '0;
            dib_q      <= '0;
            byte_cnt_q <= '0;
            dly_q      <= '0;
            crc_q      <= '0;
            type_bad_q <= 1'b0;
            off_q      <= '0;
            addr_cnt_q <= '0;
            hi_pend_q  <= 1'b0;
            hi_data_q  <= '0;
            eof_q      <= 1'b0;
            eof_ok_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            eof_q    <= eof;
            eof_ok_q <= eof && (dib_q == 2'd0) && (byte_cnt_q >= 16'd21)
                        && !type_bad_q && (crc_q == CRC_RESIDUE);
            done_q   <= eof_q;
            ok_q     <= eof_q && eof_ok_q;

            if (start_rx) begin
                crc_q      <= '1;
                byte_cnt_q <= '0;
                dib_q      <= '0;
                type_bad_q <= 1'b0;
            end else if (state_q == RX && eth_crsdv) begin
                sr_q  <= new_byte[7:2];
                dib_q <= dib_q + 2'd1;
                if (byte_done) begin
                    crc_q <= crc_byte(crc_q, new_byte);
                    if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 16'd1;
                    dly_q <= {dly_q[2:0], new_byte};
                end
            end

            if (rel_valid) begin
                if ((rel_idx == 16'd12 && rel_byte != ETHERTYPE[15:8]) ||
                    (rel_idx == 16'd13 && rel_byte != ETHERTYPE[7:0]))
                    type_bad_q <= 1'b1;
                if (rel_idx == 16'd14) off_q[7:0]  <= rel_byte;
                if (rel_idx == 16'd15) off_q[15:8] <= rel_byte;
            end

            // Each nibble write post-increments the counter, so a pixel byte advances it by 2.
            if (rel_valid && rel_idx == 16'd16) begin
                addr_cnt_q <= ADDR_BITS'({rel_byte, off_q});
            end else if (pix_wr) begin
                we_q       <= 1'b1;
                waddr_q    <= addr_cnt_q;
                wdata_q    <= rel_byte[3:0];
                hi_pend_q  <= 1'b1;
                hi_data_q  <= rel_byte[7:4];
                addr_cnt_q <= addr_cnt_q + 1'b1;
            end else if (hi_pend_q) begin
                we_q       <= 1'b1;
                waddr_q    <= addr_cnt_q;
                wdata_q    <= hi_data_q;
                hi_pend_q  <= 1'b0;
                addr_cnt_q <= addr_cnt_q + 1'b1;
            end
        end
    end

    assign write_addr_out   = waddr_q;
    assign write_data_out   = wdata_q;
    assign write_enable_out = we_q;
    assign frame_done_out   = done_q;
    assign frame_ok_out     = ok_q;

endmodule
